// File: rtl/mini_cpu_core_pkg.sv
// Shared constants for the switch-driven mini CPU core:
// opcode encodings and FSM state encodings.
package mini_cpu_core_pkg;

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_EXEC  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

endpackage

// File: rtl/mini_cpu_core_if.sv
// Display controller handshake: start pulse plus the
// opcode/register/value being shown, with busy back-pressure.
interface mini_cpu_core_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              disp_start;
    logic              disp_busy;
    logic [2:0]        disp_opcode;
    logic [ADDR_W-1:0] disp_reg_idx;
    logic [DATA_W-1:0] disp_value;

    modport master (
        output disp_start, disp_opcode,
        output disp_reg_idx, disp_value,
        input  disp_busy
    );

    modport slave (
        input  disp_start, disp_opcode,
        input  disp_reg_idx, disp_value,
        output disp_busy
    );
endinterface

// File: rtl/mini_cpu_core_button_debouncer.sv
// Synchroniser plus stability counter for the active-low
// send button; emits one-cycle press and release pulses.
module button_debouncer #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press,
    output logic rel
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1, s2, stable;
    logic [CW-1:0] cnt;

    // Idle level of the button is high, so the synchroniser resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
            rel    <= 1'b0;
        end else begin
            s1    <= btn_n;
            s2    <= s1;
            press <= 1'b0;
            rel   <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                stable <= s2;
                cnt    <= '0;
                press  <= ~s2;
                rel    <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mini_cpu_core.sv
// Mini CPU core: one instruction per debounced press, executed
// against an internal register file, result handed to the display.
module mini_cpu_core
    import mini_cpu_core_pkg::*;
#(
    parameter  int DATA_W     = 16,
    parameter  int ADDR_W     = 4,
    parameter  int IMM_W      = 6,
    parameter  int DEB_CYCLES = 50000,
    localparam int INSTR_W    = 3 + 2 * ADDR_W + IMM_W + 1
) (
    input  logic               clk,
    input  logic               ligar,
    input  logic [INSTR_W-1:0] instr,
    input  logic               enviar,
    mini_cpu_core_if.master    disp,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_v,
    output logic               busy,
    output logic [DATA_W-1:0]  leds_debug
);
    localparam int F    = IMM_W + 1;
    localparam int NREG = 2 ** ADDR_W;
    localparam int M    = DATA_W - 1;

    logic press, rel;

    button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk),
        .rst_n (ligar),
        .btn_n (enviar),
        .press (press),
        .rel   (rel)
    );

    logic [2:0]         state;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  rf [NREG];
    logic [DATA_W-1:0]  res_q;
    logic               v_q;

    logic [2:0]        op;
    logic [ADDR_W-1:0] dst, s1a, s2a;
    logic [F-1:0]      field;
    logic [DATA_W-1:0] mag, imm, a, b;

    assign op    = ir[INSTR_W-1 -: 3];
    assign dst   = ir[INSTR_W-4 -: ADDR_W];
    assign s1a   = ir[F+ADDR_W-1 -: ADDR_W];
    assign field = ir[F-1:0];
    assign s2a   = field[F-1 -: ADDR_W];
    assign mag   = {{(DATA_W-IMM_W){1'b0}}, field[IMM_W-1:0]};
    assign imm   = field[IMM_W] ? -mag : mag;
    assign a     = rf[s1a];
    assign b     = rf[s2a];

    logic [DATA_W-1:0]   rhs, sum, res;
    logic [2*DATA_W-1:0] prod;
    logic                sub, ovf, add_ovf;

    // Product of the sign-extended operands; low 2*DATA_W bits are exact.
    assign prod = {{DATA_W{a[M]}}, a} * {{DATA_W{imm[M]}}, imm};

    always_comb begin
        sub     = (op == OP_SUB) || (op == OP_SUBI);
        rhs     = ((op == OP_ADD) || (op == OP_SUB)) ? b : imm;
        sum     = sub ? a - rhs : a + rhs;
        add_ovf = sub ? (a[M] != rhs[M]) && (sum[M] != a[M])
                      : (a[M] == rhs[M]) && (sum[M] != a[M]);
        res     = sum;
        ovf     = add_ovf;
        unique case (1'b1)
            op == OP_LOAD: begin
                res = imm;
                ovf = 1'b0;
            end
            op == OP_MUL: begin
                res = prod[DATA_W-1:0];
                ovf = prod[2*DATA_W-1:DATA_W] != {DATA_W{prod[M]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge ligar) begin
        if (!ligar) begin
            state             <= ST_IDLE;
            ir                <= '0;
            res_q             <= '0;
            v_q               <= 1'b0;
            flag_z            <= 1'b0;
            flag_n            <= 1'b0;
            flag_v            <= 1'b0;
            disp.disp_opcode  <= '0;
            disp.disp_reg_idx <= '0;
            disp.disp_value   <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: if (press) begin
                    ir    <= instr;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q <= res;
                    v_q   <= ovf;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    disp.disp_opcode <= op;
                    state            <= ST_ISSUE;
                    if (op == OP_CLEAR) begin
                        for (int i = 0; i < NREG; i++) rf[i] <= '0;
                        flag_z            <= 1'b0;
                        flag_n            <= 1'b0;
                        flag_v            <= 1'b0;
                        disp.disp_value   <= '0;
                        disp.disp_reg_idx <= dst;
                    end else if (op == OP_DISPLAY) begin
                        disp.disp_value   <= a;
                        disp.disp_reg_idx <= s1a;
                    end else begin
                        rf[dst]           <= res_q;
                        flag_z            <= (res_q == '0);
                        flag_n            <= res_q[M];
                        flag_v            <= v_q;
                        disp.disp_value   <= res_q;
                        disp.disp_reg_idx <= dst;
                    end
                end
                ST_ISSUE: if (!disp.disp_busy) state <= ST_WAIT;
                ST_WAIT:  if (rel) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign disp.disp_start = (state == ST_ISSUE) && !disp.disp_busy;
    assign busy            = (state != ST_IDLE);
    assign leds_debug      = disp.disp_value;
endmodule
